pkt_to_mono_sample_converter: RTL and testbench

Converts an AXI4-Stream of interleaved stereo audio words (left, then right) into one averaged mono sample per stereo pair. It sits between the audio receive path and the visualizer sample pipeline. Everything runs in a single clock domain, with no CDC inside the block. There is no output backpressure, so the stream is never stalled after reset.

---
 rtl/pkt_to_mono_pkg.sv | 12 +
 rtl/stereo_averager.sv | 25 ++
 rtl/pkt_to_mono_sample_converter.sv | 86 ++++++++
 tb/tb_pkt_to_mono_sample_converter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pkt_to_mono_pkg.sv
// Shared types and constants for the stereo-to-mono sample converter.
// The signed/unsigned averaging mode is selected by macro PKT_TO_MONO_SIGNED_EN.
package pkt_to_mono_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic {
        WAIT_LEFT  = 1'b0,
        WAIT_RIGHT = 1'b1
    } chan_state_t;

endpackage : pkt_to_mono_pkg

// File: rtl/stereo_averager.sv
// Combinational average of a left/right pair using a one-bit-wider sum.
// Macro PKT_TO_MONO_SIGNED_EN selects two's-complement (arithmetic) versus unsigned (logical) averaging.
module stereo_averager
    import pkt_to_mono_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic [DATA_WIDTH-1:0] right_in,
    output logic [DATA_WIDTH-1:0] mono_out
);

    logic [DATA_WIDTH:0] sum;

    always_comb begin
`ifdef PKT_TO_MONO_SIGNED_EN
        sum = {left_in[DATA_WIDTH-1], left_in} + {right_in[DATA_WIDTH-1], right_in};
`else
        sum = {1'b0, left_in} + {1'b0, right_in};
`endif
        // Dropping bit 0 of the extended sum is the shift; the top bit carries the sign or carry.
        mono_out = sum[DATA_WIDTH:1];
    end

endmodule : stereo_averager

// File: rtl/pkt_to_mono_sample_converter.sv
// Accepts interleaved left/right AXI-Stream words and emits one averaged mono sample per pair.
// Averaging mode follows macro PKT_TO_MONO_SIGNED_EN (see stereo_averager).
module pkt_to_mono_sample_converter
    import pkt_to_mono_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_100MHz,
    input  logic                  rst,
    input  logic                  S_AXIS_TVALID,
    input  logic                  S_AXIS_TLAST,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    output logic                  S_AXIS_TREADY,
    output logic                  mono_sample_valid,
    output logic [DATA_WIDTH-1:0] mono_sample,
    output logic                  frame_error
);

    chan_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] mono_q, mono_d;
    logic                  mono_valid_q, mono_valid_d;
    logic                  frame_error_q, frame_error_d;
    logic                  tready_q, tready_d;
    logic                  handshake;
    logic [DATA_WIDTH-1:0] avg_out;

    stereo_averager #(.DATA_WIDTH(DATA_WIDTH)) u_averager (
        .left_in (left_q),
        .right_in(S_AXIS_TDATA),
        .mono_out(avg_out)
    );

    always_comb begin
        handshake     = S_AXIS_TVALID && tready_q;
        state_d       = state_q;
        left_d        = left_q;
        mono_d        = mono_q;
        mono_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        tready_d      = 1'b1;
        if (handshake) begin
            case (state_q)
                WAIT_LEFT: begin
                    // A TLAST on the left slot means the pair boundary is lost; drop it.
                    if (S_AXIS_TLAST) begin
                        frame_error_d = 1'b1;
                    end else begin
                        left_d  = S_AXIS_TDATA;
                        state_d = WAIT_RIGHT;
                    end
                end
                WAIT_RIGHT: begin
                    mono_d       = avg_out;
                    mono_valid_d = 1'b1;
                    state_d      = WAIT_LEFT;
                end
                default: state_d = WAIT_LEFT;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q       <= WAIT_LEFT;
            left_q        <= '0;
            mono_q        <= '0;
            mono_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            tready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            left_q        <= left_d;
            mono_q        <= mono_d;
            mono_valid_q  <= mono_valid_d;
            frame_error_q <= frame_error_d;
            tready_q      <= tready_d;
        end
    end

    assign S_AXIS_TREADY     = tready_q;
    assign mono_sample_valid = mono_valid_q;
    assign mono_sample       = mono_q;
    assign frame_error       = frame_error_q;

endmodule : pkt_to_mono_sample_converter

// File: tb/tb_pkt_to_mono_sample_converter.sv
// Scoreboard bench for pkt_to_mono_sample_converter: expected mono samples are queued at
// stimulus time and popped by a negedge monitor. Honours macro PKT_TO_MONO_SIGNED_EN.
module tb_pkt_to_mono_sample_converter;

    localparam int DW = 32;

`ifdef PKT_TO_MONO_SIGNED_EN
    localparam logic [DW-1:0] NEG_AVG = 32'hFFFF_FFFF;
`else
    localparam logic [DW-1:0] NEG_AVG = 32'h7FFF_FFFF;
`endif

    logic          clk_100MHz = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          mono_valid;
    logic [DW-1:0] mono;
    logic          frame_err;

    int            checks = 0;
    int            passed = 0;
    int            cycle = 0;
    int            fe_pending = 0;
    logic [DW-1:0] exp_q[$];
    int            pulse_cycles[$];

    pkt_to_mono_sample_converter #(.DATA_WIDTH(DW)) dut (
        .clk_100MHz       (clk_100MHz),
        .rst              (rst),
        .S_AXIS_TVALID    (s_valid),
        .S_AXIS_TLAST     (s_last),
        .S_AXIS_TDATA     (s_data),
        .S_AXIS_TREADY    (s_ready),
        .mono_sample_valid(mono_valid),
        .mono_sample      (mono),
        .frame_error      (frame_err)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [DW-1:0] actual,
                                input logic [DW-1:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Present one word for exactly one clock edge; valid is left high for back-to-back use.
    task automatic apply_stimulus(input logic [DW-1:0] data, input logic last);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    always @(negedge clk_100MHz) begin
        if (mono_valid) begin
            pulse_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                check_output("unexpected_mono_pulse", mono, 32'hDEAD_BEEF);
            end else begin
                check_output("mono_sample", mono, exp_q.pop_front());
            end
        end
        if (frame_err) begin
            checks++;
            if (fe_pending > 0) begin
                fe_pending--;
                passed++;
            end else begin
                $display("[TB] FAIL unexpected_frame_error: actual=1 required=0");
            end
        end
    end

    initial begin
        int n0;

        // Reset: everything low while rst is held.
        repeat (3) @(posedge clk_100MHz);
        #1;
        check_output("reset_tready", {31'b0, s_ready}, 32'd0);
        check_output("reset_valid", {31'b0, mono_valid}, 32'd0);
        check_output("reset_mono", mono, 32'd0);
        check_output("reset_frame_error", {31'b0, frame_err}, 32'd0);
        rst = 1'b0;
        #1;
        check_output("tready_before_edge", {31'b0, s_ready}, 32'd0);
        @(posedge clk_100MHz);
        #1;
        check_output("tready_after_release", {31'b0, s_ready}, 32'd1);

        // Pair with a long gap between left and right.
        apply_stimulus(32'h0000_0001, 1'b0);
        idle(5);
        check_output("no_pulse_in_gap", {31'b0, mono_valid}, 32'd0);
        exp_q.push_back(32'h0000_0002);
        apply_stimulus(32'h0000_0003, 1'b0);
        idle(4);
        check_output("hold_mono", mono, 32'h0000_0002);
        check_output("hold_valid_low", {31'b0, mono_valid}, 32'd0);

        // Sign/zero extension case.
        apply_stimulus(32'hFFFF_FFFF, 1'b0);
        exp_q.push_back(NEG_AVG);
        apply_stimulus(32'h0000_0000, 1'b1);
        idle(2);

        // Back-to-back pairs at full rate, including the overflow-prone pair.
        n0 = pulse_cycles.size();
        apply_stimulus(32'h7FFF_FFFF, 1'b0);
        exp_q.push_back(32'h7FFF_FFFF);
        apply_stimulus(32'h7FFF_FFFF, 1'b1);
        apply_stimulus(32'h0000_0004, 1'b0);
        exp_q.push_back(32'h0000_0005);
        apply_stimulus(32'h0000_0006, 1'b1);
        idle(3);
        if (pulse_cycles.size() >= n0 + 2) begin
            check_output("b2b_pulse_spacing", pulse_cycles[n0+1] - pulse_cycles[n0], 32'd2);
        end else begin
            check_output("b2b_pulse_count", pulse_cycles.size() - n0, 32'd2);
        end

        // Misaligned TLAST on a left slot is dropped with a frame_error pulse.
        fe_pending++;
        apply_stimulus(32'h0000_0010, 1'b1);
        apply_stimulus(32'h0000_0002, 1'b0);
        exp_q.push_back(32'h0000_0003);
        apply_stimulus(32'h0000_0004, 1'b1);
        idle(3);
        check_output("after_drop_mono", mono, 32'h0000_0003);

        // Reset while waiting for the right word discards the stored left.
        apply_stimulus(32'h0000_0008, 1'b0);
        idle(1);
        rst = 1'b1;
        @(posedge clk_100MHz);
        #1;
        rst = 1'b0;
        check_output("mid_reset_mono", mono, 32'd0);
        check_output("mid_reset_tready", {31'b0, s_ready}, 32'd0);
        @(posedge clk_100MHz);
        #1;
        check_output("mid_reset_tready_back", {31'b0, s_ready}, 32'd1);
        apply_stimulus(32'h0000_0002, 1'b0);
        idle(2);
        check_output("stale_left_no_pulse", mono, 32'd0);
        exp_q.push_back(32'h0000_0002);
        apply_stimulus(32'h0000_0002, 1'b0);
        idle(3);
        check_output("final_mono", mono, 32'h0000_0002);

        // Everything queued must have been observed.
        check_output("missing_mono_pulses", exp_q.size(), 32'd0);
        check_output("missing_frame_errors", fe_pending, 32'd0);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_pkt_to_mono_sample_converter
